// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] APB_BASE      = 32'h1000_0000;
  localparam int unsigned SLOT_SHIFT    = 12;
  localparam int unsigned IDX_W         = 4;
  localparam int unsigned DATA_W        = 32;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Response payload returned to the core alongside the ready pulse.
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Core-side request/response and APB-side bus signals of the bridge.
interface apb_master_bridge_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  // core side
  logic                     transfer;
  logic                     write;
  logic [31:0]              addr;
  logic [31:0]              wdata;
  logic [31:0]              rdata;
  logic                     ready;
  logic                     err;
  // APB side
  logic [31:0]              PADDR;
  logic                     PWRITE;
  logic                     PENABLE;
  logic [31:0]              PWDATA;
  logic [NUM_SLAVES-1:0]    PSEL;
  logic [NUM_SLAVES*32-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]    PREADY;

  // Bridge view.
  modport master (
    input  transfer, write, addr, wdata, PRDATA, PREADY,
    output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );

  // Environment view: the core plus the peripherals.
  modport slave (
    output transfer, write, addr, wdata, PRDATA, PREADY,
    input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSEL
  );
endinterface

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational address decode: upper address bits -> hit, slot index, one-hot select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4
) (
  input  logic [31:SLOT_SHIFT]   addr_hi,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic [NUM_SLAVES-1:0]  sel
);

  // Base window match plus slot range check.
  always_comb begin
    idx = addr_hi[SLOT_SHIFT +: IDX_W];
    hit = (addr_hi[31:16] == APB_BASE[31:16]) && (32'(idx) < NUM_SLAVES);
    sel = '0;
    if (hit) begin
      sel = NUM_SLAVES'(1) << idx;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns single-cycle core requests into APB SETUP/ACCESS
// sequences and returns a one-cycle ready/err/rdata response.
// Optional build macro: APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES
// cycles without PREADY and answers with err=1, rdata=32'hDEAD_BEEF.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                 PCLK,
  input logic                 PRESET,
  apb_master_bridge_if.master bus
);

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  apb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [31:0]           paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  ready_q, ready_d;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  slot_ready;
  logic [31:0]           slot_rdata;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_dec (
    .addr_hi (bus.addr[31:SLOT_SHIFT]),
    .hit     (dec_hit),
    .idx     (dec_idx),
    .sel     (dec_sel)
  );

  // Only the selected slot's PREADY counts.
  assign slot_ready = |(bus.PREADY & psel_q);

  // Read data mux on the latched slot index.
  always_comb begin
    slot_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slot_rdata = bus.PRDATA[32*i +: 32];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    idx_d     = idx_q;
    rsp_d     = '0;
    ready_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          if (dec_hit) begin
            paddr_d  = bus.addr;
            pwrite_d = bus.write;
            pwdata_d = bus.wdata;
            idx_d    = dec_idx;
            psel_d   = dec_sel;
            state_d  = SETUP;
          end else begin
            ready_d   = 1'b1;
            rsp_d.err = 1'b1;
          end
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (slot_ready) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          ready_d     = 1'b1;
          rsp_d.rdata = pwrite_q ? 32'h0 : slot_rdata;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          ready_d     = 1'b1;
          rsp_d.err   = 1'b1;
          rsp_d.rdata = TIMEOUT_RDATA;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      idx_q     <= '0;
      rsp_q     <= '0;
      ready_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      idx_q     <= idx_d;
      rsp_q     <= rsp_d;
      ready_q   <= ready_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.PSEL    = psel_q;
  assign bus.PENABLE = penable_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.rdata   = rsp_q.rdata;
  assign bus.err     = rsp_q.err;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge with a scoreboard of expected responses.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 64;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic PCLK;
  logic PRESET;

  apb_master_bridge_if #(.NUM_SLAVES(NS)) bus ();

  apb_master_bridge #(
    .NUM_SLAVES     (NS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  logic [NS-1:0] slv_rdy;
  logic [NS-1:0] hold_rdy;
  int            wait_cfg [NS];
  int            acc_cnt  [NS];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  assign bus.PREADY = slv_rdy | hold_rdy;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Registered slave model: raises PREADY wait_cfg cycles after seeing ACCESS.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      slv_rdy <= '0;
      for (int i = 0; i < NS; i++) acc_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (bus.PSEL[i] && bus.PENABLE && !slv_rdy[i]) begin
          if (acc_cnt[i] >= wait_cfg[i]) slv_rdy[i] <= 1'b1;
          else acc_cnt[i] <= acc_cnt[i] + 1;
        end else begin
          slv_rdy[i] <= 1'b0;
          acc_cnt[i] <= 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every ready pulse.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (bus.ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ready", 64'(bus.ready), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rsp_rdata", 64'(bus.rdata), 64'(e.rdata));
          check("rsp_err", 64'(bus.err), 64'(e.err));
        end
      end else begin
        check("idle_rsp", 64'({bus.rdata, bus.err}), 64'd0);
      end
    end
  end

  // Drive one request for a cycle and record its expected response.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
    bus.transfer = 1'b1;
    bus.write    = w;
    bus.addr     = a;
    bus.wdata    = d;
    @(negedge PCLK);
    bus.transfer = 1'b0;
  endtask

  // Wait (bounded) for ready; reports the number of cycles waited.
  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    check(tag, 64'(bus.ready), 64'd1);
  endtask

  initial begin
    int lat;
    PRESET       = 1'b1;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    bus.PRDATA   = {32'h3333_0303, 32'h2222_0202, 32'h0000_00A5, 32'h1111_0101};
    hold_rdy     = '0;
    for (int i = 0; i < NS; i++) wait_cfg[i] = 0;

    repeat (2) @(negedge PCLK);
    check("rst_psel", 64'(bus.PSEL), 64'd0);
    check("rst_penable", 64'(bus.PENABLE), 64'd0);
    check("rst_paddr", 64'(bus.PADDR), 64'd0);
    check("rst_pwrite", 64'(bus.PWRITE), 64'd0);
    check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
    check("rst_rsp", 64'({bus.rdata, bus.ready, bus.err}), 64'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Write to slot 0, PREADY one cycle into ACCESS.
    issue(1'b1, 32'h1000_0004, 32'h0000_00FF, 32'h0, 1'b0);
    check("wr_psel_t1", 64'(bus.PSEL), 64'b0001);
    check("wr_penable_t1", 64'(bus.PENABLE), 64'd0);
    check("wr_paddr", 64'(bus.PADDR), 64'h1000_0004);
    check("wr_pwrite", 64'(bus.PWRITE), 64'd1);
    check("wr_pwdata", 64'(bus.PWDATA), 64'h0000_00FF);
    @(negedge PCLK);
    check("wr_penable_t2", 64'(bus.PENABLE), 64'd1);
    check("wr_psel_t2", 64'(bus.PSEL), 64'b0001);
    @(negedge PCLK);
    check("wr_ready_t3", 64'(bus.ready), 64'd0);
    @(negedge PCLK);
    check("wr_ready_t4", 64'(bus.ready), 64'd1);
    check("wr_psel_t4", 64'(bus.PSEL), 64'd0);

    // Back-to-back: new request in the ready cycle.
    issue(1'b1, 32'h1000_2008, 32'h1234_5678, 32'h0, 1'b0);
    check("b2b_psel", 64'(bus.PSEL), 64'b0100);
    wait_done("b2b_done", 20, lat);
    check("b2b_lat", 64'(lat), 64'd3);
    @(negedge PCLK);

    // Read slot 1 while non-selected slot 3 holds PREADY high.
    hold_rdy = 4'b1000;
    issue(1'b0, 32'h1000_1004, 32'h0, 32'h0000_00A5, 1'b0);
    check("rd_psel", 64'(bus.PSEL), 64'b0010);
    check("rd_paddr", 64'(bus.PADDR), 64'h1000_1004);
    check("rd_pwrite", 64'(bus.PWRITE), 64'd0);
    wait_done("rd_done", 20, lat);
    check("rd_lat", 64'(lat), 64'd3);
    hold_rdy = '0;
    @(negedge PCLK);

    // Slow write to slot 1; a transfer during ACCESS must be ignored.
    wait_cfg[1] = 2;
    issue(1'b1, 32'h1000_1010, 32'hCAFE_0001, 32'h0, 1'b0);
    @(negedge PCLK);
    bus.transfer = 1'b1;
    bus.write    = 1'b0;
    bus.addr     = 32'h1000_0000;
    bus.wdata    = 32'h0;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    check("ign_paddr", 64'(bus.PADDR), 64'h1000_1010);
    check("ign_psel", 64'(bus.PSEL), 64'b0010);
    check("ign_pwdata", 64'(bus.PWDATA), 64'hCAFE_0001);
    wait_done("slow_done", 20, lat);
    check("slow_lat", 64'(lat), 64'd3);
    wait_cfg[1] = 0;
    @(negedge PCLK);

    // Minimum latency: slot 2 PREADY already high.
    hold_rdy = 4'b0100;
    issue(1'b0, 32'h1000_2000, 32'h0, 32'h2222_0202, 1'b0);
    check("min_psel", 64'(bus.PSEL), 64'b0100);
    @(negedge PCLK);
    check("min_penable", 64'(bus.PENABLE), 64'd1);
    @(negedge PCLK);
    check("min_ready_t3", 64'(bus.ready), 64'd1);
    hold_rdy = '0;
    @(negedge PCLK);

    // Decode misses.
    issue(1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1);
    check("miss1_psel", 64'(bus.PSEL), 64'd0);
    check("miss1_ready", 64'(bus.ready), 64'd1);
    check("miss1_paddr", 64'(bus.PADDR), 64'h1000_2000);
    @(negedge PCLK);
    check("miss1_ready_off", 64'(bus.ready), 64'd0);
    issue(1'b1, 32'h1000_4000, 32'h55, 32'h0, 1'b1);
    check("miss2_psel", 64'(bus.PSEL), 64'd0);
    check("miss2_ready", 64'(bus.ready), 64'd1);
    @(negedge PCLK);

`ifdef APB_TIMEOUT_EN
    // Timeout on slot 3.
    begin
      int acc = 0;
      int n   = 0;
      wait_cfg[3] = 100000;
      issue(1'b0, 32'h1000_3000, 32'h0, 32'hDEAD_BEEF, 1'b1);
      while (bus.PSEL != '0 && n < 500) begin
        if (bus.PENABLE) acc++;
        @(negedge PCLK);
        n++;
      end
      check("to_access_cycles", 64'(acc), 64'(TO));
      check("to_ready", 64'(bus.ready), 64'd1);
      @(negedge PCLK);
    end
`endif

    // Reset in ACCESS on a stalled slot 3.
    wait_cfg[3] = 100000;
    issue(1'b0, 32'h1000_3000, 32'h0, 32'h3333_0303, 1'b0);
    repeat (3) @(negedge PCLK);
    check("rstacc_penable_pre", 64'(bus.PENABLE), 64'd1);
    PRESET = 1'b1;
    sb_q.delete();
    #1;
    check("rstacc_psel", 64'(bus.PSEL), 64'd0);
    check("rstacc_penable", 64'(bus.PENABLE), 64'd0);
    check("rstacc_ready", 64'(bus.ready), 64'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    wait_cfg[3] = 0;
    issue(1'b0, 32'h1000_3004, 32'h0, 32'h3333_0303, 1'b0);
    check("post_rst_psel", 64'(bus.PSEL), 64'b1000);
    wait_done("post_rst_done", 20, lat);
    check("post_rst_lat", 64'(lat), 64'd3);

    repeat (3) @(negedge PCLK);
    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
